mdsa_host_bridge: RTL and testbench

MDSA_HOST_BRIDGE -- requirements
Module: mdsa_host_bridge

---
 rtl/mdsa_pkg.sv | 22 ++
 rtl/mdsa_host_bridge_if.sv | 42 ++++
 rtl/mdsa_word_serializer.sv | 75 +++++++
 rtl/mdsa_host_bridge.sv | 110 +++++++++++
 tb/tb_mdsa_host_bridge.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/mdsa_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mdsa_pkg : shared sizes and FSM state encoding for the MDSA host bridge
// Revision : 1.0
// ---------------------------------------------------------------------------
package mdsa_pkg;

    localparam int N     = 8;
    localparam int DW    = 32;
    localparam int WORDS = N * N;
    localparam int BUS_W = WORDS * DW;
    localparam int CNT_W = $clog2(WORDS);

    typedef enum logic [1:0] {
        ST_LOAD      = 2'd0,
        ST_LAUNCH    = 2'd1,
        ST_WAIT_SORT = 2'd2,
        ST_DRAIN     = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mdsa_host_bridge_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mdsa_host_bridge_if : upstream, downstream and sorter signals of the bridge
// Revision : 1.0
// ---------------------------------------------------------------------------
interface mdsa_host_bridge_if #(
    parameter int N  = mdsa_pkg::N,
    parameter int DW = mdsa_pkg::DW
);
    import mdsa_pkg::*;

    logic                in_valid;
    logic [DW-1:0]       in_data;
    logic                in_ready;
    logic                out_valid;
    logic [DW-1:0]       out_data;
    logic                out_last;
    logic                out_ready;
    logic                sort_en;
    logic                sort_start;
    logic [N*N*DW-1:0]   sort_data_in;
    logic                sort_rdy;
    logic                sort_oe;
    logic [N*N*DW-1:0]   sort_data_out;
    logic                busy;

    // Bridge side
    modport slave (
        input  in_valid, in_data, out_ready, sort_rdy, sort_oe, sort_data_out,
        output in_ready, out_valid, out_data, out_last,
               sort_en, sort_start, sort_data_in, busy
    );

    // Environment side (upstream source, downstream sink, sorter)
    modport master (
        output in_valid, in_data, out_ready, sort_rdy, sort_oe, sort_data_out,
        input  in_ready, out_valid, out_data, out_last,
               sort_en, sort_start, sort_data_in, busy
    );

endinterface
`default_nettype wire

// File: rtl/mdsa_word_serializer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mdsa_word_serializer : captures a sorted matrix and streams it word by word
// Revision : 1.0
// ---------------------------------------------------------------------------
module mdsa_word_serializer #(
    parameter int N  = mdsa_pkg::N,
    parameter int DW = mdsa_pkg::DW
) (
    input  wire logic                clk,
    input  wire logic                rst,
    input  wire logic                capture_i,
    input  wire logic [N*N*DW-1:0]   matrix_i,
    input  wire logic                out_ready_i,
    output logic                     out_valid_o,
    output logic [DW-1:0]            out_data_o,
    output logic                     out_last_o,
    output logic                     done_o
);
    import mdsa_pkg::*;

    localparam int                 c_WORDS = N * N;
    localparam int                 c_CNT_W = $clog2(c_WORDS);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(c_WORDS - 1);

    logic [c_WORDS-1:0][DW-1:0] buf_q;
    logic [c_CNT_W-1:0]         rd_cnt_q;
    logic                       out_valid_q;
    logic [DW-1:0]              out_data_q;
    logic                       out_last_q;
    logic [c_CNT_W-1:0]         w_rd_cnt_d;
    logic                       w_out_hs;

    assign w_rd_cnt_d = rd_cnt_q + 1'b1;
    assign w_out_hs   = out_valid_q & out_ready_i;

    // Matrix storage carries no reset; it is always overwritten before use.
    always_ff @(posedge clk) begin
        if (capture_i) begin
            buf_q <= matrix_i;
        end
    end

    // Next word is pre-fetched on each handshake so out_data stays a register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_cnt_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else if (capture_i) begin
            rd_cnt_q    <= '0;
            out_valid_q <= 1'b1;
            out_data_q  <= matrix_i[DW-1:0];
            out_last_q  <= 1'b0;
        end else if (w_out_hs) begin
            if (rd_cnt_q == c_LAST) begin
                rd_cnt_q    <= '0;
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end else begin
                rd_cnt_q    <= w_rd_cnt_d;
                out_data_q  <= buf_q[w_rd_cnt_d];
                out_last_q  <= (w_rd_cnt_d == c_LAST);
            end
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_last_o  = out_last_q;
    assign done_o      = w_out_hs & out_last_q;

endmodule
`default_nettype wire

// File: rtl/mdsa_host_bridge.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mdsa_host_bridge : packs a word stream into a matrix, runs the sorter, streams result
// Revision : 1.0
// ---------------------------------------------------------------------------
module mdsa_host_bridge #(
    parameter int N  = mdsa_pkg::N,
    parameter int DW = mdsa_pkg::DW
) (
    input  wire logic          clk,
    input  wire logic          rst,
    mdsa_host_bridge_if.slave  bus
);
    import mdsa_pkg::*;

    localparam int                 c_WORDS = N * N;
    localparam int                 c_CNT_W = $clog2(c_WORDS);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(c_WORDS - 1);

    state_t                     state_q;
    logic [c_CNT_W-1:0]         wr_cnt_q;
    logic                       in_ready_q;
    logic                       busy_q;
    logic                       sort_en_q;
    logic [c_WORDS-1:0][DW-1:0] in_buf_q;

    logic w_in_hs;
    logic w_capture;
    logic w_done;

    // in_ready is only ever high in LOAD, so a handshake implies LOAD.
    assign w_in_hs   = bus.in_valid & in_ready_q;
    assign w_capture = (state_q == ST_WAIT_SORT) & bus.sort_oe;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_LOAD;
            wr_cnt_q   <= '0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            sort_en_q  <= 1'b0;
        end else begin
            sort_en_q <= 1'b1;
            case (state_q)
                ST_LOAD: begin
                    if (w_in_hs) begin
                        if (wr_cnt_q == c_LAST) begin
                            wr_cnt_q   <= '0;
                            in_ready_q <= 1'b0;
                            busy_q     <= 1'b1;
                            state_q    <= ST_LAUNCH;
                        end else begin
                            wr_cnt_q <= wr_cnt_q + 1'b1;
                        end
                    end
                end
                ST_LAUNCH: begin
                    if (bus.sort_rdy) begin
                        state_q <= ST_WAIT_SORT;
                    end
                end
                ST_WAIT_SORT: begin
                    if (bus.sort_oe) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_done) begin
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b0;
                        state_q    <= ST_LOAD;
                    end
                end
                default: begin
                    state_q <= ST_LOAD;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_in_hs) begin
            in_buf_q[wr_cnt_q] <= bus.in_data;
        end
    end

    mdsa_word_serializer #(
        .N  (N),
        .DW (DW)
    ) u_serializer (
        .clk         (clk),
        .rst         (rst),
        .capture_i   (w_capture),
        .matrix_i    (bus.sort_data_out),
        .out_ready_i (bus.out_ready),
        .out_valid_o (bus.out_valid),
        .out_data_o  (bus.out_data),
        .out_last_o  (bus.out_last),
        .done_o      (w_done)
    );

    // Start must coincide with the cycle the sorter reports ready.
    assign bus.sort_start   = (state_q == ST_LAUNCH) & bus.sort_rdy;
    assign bus.in_ready     = in_ready_q;
    assign bus.busy         = busy_q;
    assign bus.sort_en      = sort_en_q;
    assign bus.sort_data_in = in_buf_q;

endmodule
`default_nettype wire

// File: tb/tb_mdsa_host_bridge.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mdsa_host_bridge : directed self-checking bench for mdsa_host_bridge
// Revision : 1.0
// ---------------------------------------------------------------------------
module tb_mdsa_host_bridge;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    mdsa_host_bridge_if bus ();

    mdsa_host_bridge dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [2047:0] m, input int k);
        return m[k*32 +: 32];
    endfunction

    // Upstream word k of a batch with the given base is base+63-k.
    task automatic load_words(input int first, input int count, input int base);
        for (int k = first; k < first + count; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 32'(base + 63 - k);
            #1;
            chk1("in_ready_load", bus.in_ready, 1'b1);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic chk_matrix(input int base);
        for (int k = 0; k < 64; k++) begin
            chkw("sort_data_in", word_of(bus.sort_data_in, k), 32'(base + 63 - k));
        end
    endtask

    task automatic launch_expect();
        chk1("in_ready_launch", bus.in_ready, 1'b0);
        chk1("busy_launch", bus.busy, 1'b1);
        chk1("sort_start_pulse", bus.sort_start, 1'b1);
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            chk1("sort_start_single", bus.sort_start, 1'b0);
            chk1("out_valid_wait", bus.out_valid, 1'b0);
            chk1("in_ready_wait", bus.in_ready, 1'b0);
            @(posedge clk); #1;
        end
    endtask

    task automatic sorter_return(input int base);
        logic [2047:0] m;
        for (int k = 0; k < 64; k++) m[k*32 +: 32] = 32'(base + k);
        bus.sort_data_out = m;
        bus.sort_oe       = 1'b1;
        @(posedge clk); #1;
        bus.sort_oe       = 1'b0;
        bus.sort_data_out = '1;
    endtask

    task automatic drain(input int base, input int nwords, input bit stall);
        int idx = 0;
        int cyc = 0;
        bit hs;
        while (idx < nwords && cyc < 2000) begin
            bus.out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            chk1("out_valid_drain", bus.out_valid, 1'b1);
            chkw("out_data", bus.out_data, 32'(base + idx));
            chk1("out_last", bus.out_last, idx == 63);
            hs = bus.out_ready;
            @(posedge clk); #1;
            cyc++;
            if (hs) idx++;
        end
        bus.out_ready = 1'b0;
        chkw("drain_count", 32'(idx), 32'(nwords));
        if (nwords == 64) begin
            if (!stall) chkw("drain_cycles", 32'(cyc), 32'd64);
            chk1("in_ready_after_drain", bus.in_ready, 1'b1);
            chk1("out_valid_after_drain", bus.out_valid, 1'b0);
            chk1("busy_after_drain", bus.busy, 1'b0);
        end
    endtask

    task automatic reset_pulse();
        #1;
        rst = 1'b0;
        #1;
        chk1("rst_sort_en", bus.sort_en, 1'b0);
        chk1("rst_busy", bus.busy, 1'b0);
        chk1("rst_out_valid", bus.out_valid, 1'b0);
        chk1("rst_out_last", bus.out_last, 1'b0);
        chk1("rst_sort_start", bus.sort_start, 1'b0);
        chk1("rst_in_ready", bus.in_ready, 1'b1);
        @(posedge clk); #2;
        rst = 1'b1;
        @(posedge clk); #1;
        chk1("post_rst_sort_en", bus.sort_en, 1'b1);
        chk1("post_rst_in_ready", bus.in_ready, 1'b1);
        chk1("post_rst_busy", bus.busy, 1'b0);
        chk1("post_rst_out_valid", bus.out_valid, 1'b0);
    endtask

    initial begin
        checks            = 0;
        failures          = 0;
        rst               = 1'b1;
        bus.in_valid      = 1'b0;
        bus.in_data       = '0;
        bus.out_ready     = 1'b0;
        bus.sort_rdy      = 1'b1;
        bus.sort_oe       = 1'b0;
        bus.sort_data_out = '0;
        @(posedge clk); #1;
        reset_pulse();

        // Batch A: descending 63..0, sorter ready, no stalls; held in_valid outside LOAD.
        load_words(0, 64, 0);
        chkw("word0_is_63", word_of(bus.sort_data_in, 0), 32'd63);
        chk_matrix(0);
        bus.in_valid = 1'b1;
        bus.in_data  = 32'd999;
        launch_expect();
        sorter_return(0);
        drain(0, 64, 1'b0);
        bus.in_valid = 1'b0;
        chkw("frozen_word0", word_of(bus.sort_data_in, 0), 32'd63);
        chkw("frozen_word63", word_of(bus.sort_data_in, 63), 32'd0);

        // Batch B: sorter not ready for 5 cycles, random downstream stalls.
        bus.sort_rdy = 1'b0;
        load_words(0, 64, 50);
        for (int i = 0; i < 5; i++) begin
            chk1("sort_start_held", bus.sort_start, 1'b0);
            chk1("in_ready_held", bus.in_ready, 1'b0);
            chk1("busy_held", bus.busy, 1'b1);
            @(posedge clk); #1;
        end
        bus.sort_rdy = 1'b1;
        #1;
        chk1("sort_start_on_rdy", bus.sort_start, 1'b1);
        @(posedge clk); #1;
        chk1("sort_start_after_rdy", bus.sort_start, 1'b0);
        @(posedge clk); #1;
        sorter_return(2000);
        drain(2000, 64, 1'b1);

        // Batch C: spurious sort_oe while loading.
        load_words(0, 20, 200);
        bus.sort_data_out = {64{32'hDEAD_BEEF}};
        bus.sort_oe       = 1'b1;
        @(posedge clk); #1;
        bus.sort_oe       = 1'b0;
        chk1("spurious_out_valid", bus.out_valid, 1'b0);
        chk1("spurious_busy", bus.busy, 1'b0);
        chk1("spurious_in_ready", bus.in_ready, 1'b1);
        @(posedge clk); #1;
        chk1("spurious_out_valid2", bus.out_valid, 1'b0);
        load_words(20, 44, 200);
        chk_matrix(200);
        launch_expect();
        sorter_return(300);
        drain(300, 64, 1'b1);

        // Reset after 30 words, then a clean batch.
        load_words(0, 30, 500);
        reset_pulse();
        load_words(0, 64, 600);
        chk_matrix(600);
        launch_expect();
        sorter_return(700);
        drain(700, 64, 1'b0);

        // Reset in the middle of DRAIN, then a clean batch.
        load_words(0, 64, 800);
        launch_expect();
        sorter_return(900);
        drain(900, 10, 1'b1);
        reset_pulse();
        load_words(0, 64, 1000);
        chk_matrix(1000);
        launch_expect();
        sorter_return(1100);
        drain(1100, 64, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
